// File: rtl/wb_burst_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_burst_tester                                                  |
// | Brief   : Wishbone B4 master that writes patterned bursts, reads them back |
// |           and counts mismatches and bus errors.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_burst_tester #(
   parameter int unsigned   AW         = 32,
   parameter int unsigned   DW         = 32,
   parameter logic [AW-1:0] BASE_ADR   = AW'(32'h1000),
   parameter int unsigned   BEATS      = 4,
   parameter int unsigned   BURSTS     = 1,
   parameter bit            BURST_MODE = 1'b1,
   parameter logic [DW-1:0] PATTERN    = DW'(32'h12345678)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [AW-1:0]   adr,
   output logic [1:0]      bte,
   output logic [2:0]      cti,
   output logic            cyc,
   output logic            stb,
   output logic            we,
   output logic [DW/8-1:0] sel,
   output logic [DW-1:0]   dat,
   input  logic            ack,
   input  logic            err,
   input  logic [DW-1:0]   dat_i,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [15:0]     err_cnt
);
   localparam int unsigned     c_IW         = $clog2(BEATS*BURSTS+1);
   localparam int unsigned     c_BW         = $clog2(BEATS+1);
   localparam int unsigned     c_NW         = $clog2(BURSTS+1);
   localparam logic [AW-1:0]   c_STEP       = AW'(DW/8);
   localparam logic [c_BW-1:0] c_LAST_BEAT  = c_BW'(BEATS-1);
   localparam logic [c_NW-1:0] c_LAST_BURST = c_NW'(BURSTS-1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_WGAP = 3'd2,
      S_RGAP = 3'd3,
      S_RD   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t          r_state, w_state;
   logic [AW-1:0]   r_adr, w_adr;
   logic [DW-1:0]   r_dat, w_dat;
   logic [2:0]      r_cti, w_cti;
   logic            r_cyc, w_cyc;
   logic            r_we, w_we;
   logic [c_IW-1:0] r_idx, w_idx;
   logic [c_BW-1:0] r_beat, w_beat;
   logic [c_NW-1:0] r_burst, w_burst;
   logic [15:0]     r_err_cnt, w_err_cnt;
   logic            r_busy, w_busy;
   logic            r_done, w_done;
   logic            r_pass, w_pass;

   logic            w_hit;
   logic            w_err_inc;
   logic [DW-1:0]   w_exp;
   logic [c_IW-1:0] w_idx_inc;
   logic [c_BW-1:0] w_beat_inc;

   function automatic logic [2:0] f_cti(input logic [c_BW-1:0] beat);
      if (!BURST_MODE)
         return 3'b000;
      return (beat == c_LAST_BEAT) ? 3'b111 : 3'b010;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_adr     <= BASE_ADR;
         r_dat     <= '0;
         r_cti     <= 3'b000;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_idx     <= '0;
         r_beat    <= '0;
         r_burst   <= '0;
         r_err_cnt <= 16'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_adr     <= w_adr;
         r_dat     <= w_dat;
         r_cti     <= w_cti;
         r_cyc     <= w_cyc;
         r_we      <= w_we;
         r_idx     <= w_idx;
         r_beat    <= w_beat;
         r_burst   <= w_burst;
         r_err_cnt <= w_err_cnt;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_pass    <= w_pass;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_adr      = r_adr;
      w_dat      = r_dat;
      w_cti      = r_cti;
      w_cyc      = r_cyc;
      w_we       = r_we;
      w_idx      = r_idx;
      w_beat     = r_beat;
      w_burst    = r_burst;
      w_busy     = r_busy;
      w_done     = r_done;
      w_pass     = r_pass;
      w_hit      = r_cyc & (ack | err);
      w_exp      = PATTERN ^ DW'(r_idx);
      w_idx_inc  = r_idx + c_IW'(1);
      w_beat_inc = r_beat + c_BW'(1);
      // err wins over data compare, so ack+err together costs a single count
      w_err_inc  = w_hit & (err | ((r_state == S_RD) & (dat_i != w_exp)));
      w_err_cnt  = r_err_cnt;
      if (w_err_inc && (r_err_cnt != 16'hFFFF))
         w_err_cnt = r_err_cnt + 16'd1;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state   = S_WR;
               w_adr     = BASE_ADR;
               w_dat     = PATTERN;
               w_cti     = f_cti('0);
               w_cyc     = 1'b1;
               w_we      = 1'b1;
               w_idx     = '0;
               w_beat    = '0;
               w_burst   = '0;
               w_err_cnt = 16'd0;
               w_busy    = 1'b1;
               w_done    = 1'b0;
               w_pass    = 1'b0;
            end
         end
         S_WR, S_RD: begin
            if (w_hit) begin
               w_adr = r_adr + c_STEP;
               w_idx = w_idx_inc;
               if (r_beat == c_LAST_BEAT) begin
                  w_beat = '0;
                  w_cyc  = 1'b0;
                  w_we   = 1'b0;
                  w_dat  = '0;
                  w_cti  = 3'b000;
                  if (r_burst != c_LAST_BURST) begin
                     w_burst = r_burst + c_NW'(1);
                     w_state = (r_state == S_WR) ? S_WGAP : S_RGAP;
                  end else if (r_state == S_WR) begin
                     // read-back restarts from the base of the written region
                     w_burst = '0;
                     w_adr   = BASE_ADR;
                     w_idx   = '0;
                     w_state = S_RGAP;
                  end else begin
                     w_state = S_DONE;
                     w_busy  = 1'b0;
                     w_done  = 1'b1;
                     w_pass  = (w_err_cnt == 16'd0);
                  end
               end else begin
                  w_beat = w_beat_inc;
                  w_cti  = f_cti(w_beat_inc);
                  if (r_state == S_WR)
                     w_dat = PATTERN ^ DW'(w_idx_inc);
               end
            end
         end
         S_WGAP: begin
            w_state = S_WR;
            w_cyc   = 1'b1;
            w_we    = 1'b1;
            w_dat   = PATTERN ^ DW'(r_idx);
            w_cti   = f_cti('0);
         end
         S_RGAP: begin
            w_state = S_RD;
            w_cyc   = 1'b1;
            w_we    = 1'b0;
            w_dat   = '0;
            w_cti   = f_cti('0);
         end
         default: begin
            w_state = S_IDLE;
            w_cyc   = 1'b0;
            w_we    = 1'b0;
         end
      endcase
   end

   assign adr     = r_adr;
   assign bte     = 2'b00;
   assign cti     = r_cti;
   assign cyc     = r_cyc;
   assign stb     = r_cyc;
   assign we      = r_we;
   assign sel     = '1;
   assign dat     = r_dat;
   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_wb_burst_tester                                               |
// | Brief   : Randomised bench: memory slave, expected-beat queue, fault inject|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_burst_tester;
   localparam int          BEATS  = 4;
   localparam int          BURSTS = 2;
   localparam int          TOTAL  = BEATS * BURSTS;
   localparam logic [31:0] BASE   = 32'h1000;
   localparam logic [31:0] PAT    = 32'h12345678;
   localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] adr, dat, dat_i;
   logic [1:0]  bte;
   logic [2:0]  cti;
   logic        cyc, stb, we, ack, err, busy, done, pass;
   logic [3:0]  sel;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   wb_burst_tester #(
      .AW(32), .DW(32), .BASE_ADR(BASE), .BEATS(BEATS), .BURSTS(BURSTS),
      .BURST_MODE(1'b1), .PATTERN(PAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .adr(adr), .bte(bte), .cti(cti),
      .cyc(cyc), .stb(stb), .we(we), .sel(sel), .dat(dat), .ack(ack), .err(err),
      .dat_i(dat_i), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory slave with selectable wait behaviour and fault injection
   logic [31:0] mem [0:63];
   int          mode = 0;
   int unsigned slow_ctr = 0;
   logic        ack_en = 1'b1;
   logic [31:0] flip_adr = NONE, err_radr = NONE, err_wadr = NONE;

   assign ack   = cyc & stb & ack_en;
   assign err   = cyc & stb & ack_en & ((we && adr == err_wadr) || (!we && adr == err_radr));
   assign dat_i = mem[adr[7:2]] ^ {31'd0, (!we && adr == flip_adr)};

   always @(posedge clk)
      if (cyc && stb && we && ack_en) mem[adr[7:2]] <= dat;

   always @(posedge clk) begin
      #2;
      slow_ctr = slow_ctr + 1;
      case (mode)
         0:       ack_en = 1'b1;
         1:       ack_en = (slow_ctr % 3 == 0);
         default: ack_en = ($urandom_range(0, 2) != 0);
      endcase
   end

   // reference: the full list of beats a correct run must present, in order
   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [2:0]  cti;
   } beat_t;

   beat_t exp_q[$];
   int    exp_err, gap_cnt;
   bit    mon_en = 1'b0, last_seen = 1'b0, held = 1'b0;
   beat_t held_b;

   task automatic build();
      exp_q.delete();
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < TOTAL; i++) begin
            beat_t b;
            b.adr = BASE + 32'(4 * i);
            b.we  = (ph == 0);
            b.dat = (ph == 0) ? (PAT ^ 32'(i)) : 32'd0;
            b.cti = ((i % BEATS) == BEATS - 1) ? 3'b111 : 3'b010;
            exp_q.push_back(b);
         end
      end
   endtask

   always @(negedge clk) begin : mon
      beat_t e;
      if (mon_en) begin
         if (last_seen) begin
            chk("done_rise", done, 1);
            chk("busy_fall", busy, 0);
            last_seen = 1'b0;
         end
         if (busy && !cyc) gap_cnt++;
         if (cyc && stb && held) begin
            chk("hold_adr", adr, held_b.adr);
            chk("hold_dat", dat, held_b.dat);
            chk("hold_cti", cti, held_b.cti);
            chk("hold_we", we, held_b.we);
         end
         if (cyc && stb && (ack || err)) begin
            held = 1'b0;
            chk("beat_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("beat_adr", adr, e.adr);
               chk("beat_we", we, e.we);
               chk("beat_dat", dat, e.dat);
               chk("beat_cti", cti, e.cti);
               if ((e.we && e.adr == err_wadr) ||
                   (!e.we && (e.adr == err_radr || e.adr == flip_adr)))
                  exp_err++;
               if (exp_q.size() == 0) last_seen = 1'b1;
            end
         end else if (cyc && stb) begin
            held   = 1'b1;
            held_b = '{adr, we, dat, cti};
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic run(input int m, input logic [31:0] fa, input logic [31:0] er,
                      input logic [31:0] ew, input bit poke);
      mode = m; flip_adr = fa; err_radr = er; err_wadr = ew;
      build();
      exp_err = 0; gap_cnt = 0; held = 1'b0; last_seen = 1'b0;
      @(negedge clk); start = 1'b1; mon_en = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("launch_cyc", cyc, 1);
      chk("launch_busy", busy, 1);
      chk("launch_done", done, 0);
      for (int c = 0; c < 2000 && !done; c++) begin
         start = (poke && c == 5);
         @(negedge clk);
      end
      start = 1'b0;
      chk("run_done", done, 1);
      @(negedge clk);
      mon_en = 1'b0;
      chk("left_beats", exp_q.size(), 0);
      chk("err_cnt", err_cnt, exp_err);
      chk("pass", pass, exp_err == 0);
      chk("gaps", gap_cnt, 2 * BURSTS - 1);
   endtask

   initial begin
      logic [31:0] fa, er, ew;
      reset = 1'b1; start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_cyc", cyc, 0);
      chk("rst_adr", adr, BASE);
      chk("rst_done", done, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pass", pass, 0);
      chk("rst_dat", dat, 0);
      chk("rst_sel", sel, 4'hF);
      chk("rst_bte", bte, 0);
      chk("rst_cti", cti, 0);

      run(0, NONE, NONE, NONE, 1'b0);
      chk("zw_pass", pass, 1);
      run(1, NONE, NONE, NONE, 1'b0);
      chk("slow_err_cnt", err_cnt, 0);
      run(0, BASE + 32'h8, BASE + 32'hC, NONE, 1'b0);
      chk("fault_err_cnt", err_cnt, 2);
      chk("fault_pass", pass, 0);

      for (int k = 0; k < 6; k++) begin
         fa = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * $urandom_range(0, TOTAL - 1)) : NONE;
         er = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * $urandom_range(0, TOTAL - 1)) : NONE;
         ew = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * $urandom_range(0, TOTAL - 1)) : NONE;
         run(2, fa, er, ew, k[0]);
      end

      // reset while write beat 2 is on the bus
      mode = 0; flip_adr = NONE; err_radr = NONE; err_wadr = NONE;
      build(); held = 1'b0; last_seen = 1'b0;
      @(negedge clk); start = 1'b1; mon_en = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 200 && exp_q.size() > 2 * TOTAL - 2; c++) begin
         @(negedge clk); #1;
      end
      chk("rst_reach", exp_q.size(), 2 * TOTAL - 2);
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_cyc", cyc, 0);
      chk("mid_rst_stb", stb, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_adr", adr, BASE);
      @(negedge clk); reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", cyc, 0);
      chk("post_rst_done", done, 0);

      run(0, NONE, NONE, NONE, 1'b1);
      chk("relaunch_pass", pass, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
`default_nettype wire
